// File: rtl/emu_dt_sched.sv
// Global timestep scheduler: issues the minimum eligible per-block dt request,
// accumulates emulated time and sequences run, pause and stop-at-time.
module emu_dt_sched #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DT_WIDTH   = 27,
    parameter int unsigned TIME_WIDTH = 48
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    input  logic [N_REQ-1:0]          req_en,
    input  logic                      start,
    input  logic                      pause,
    input  logic [TIME_WIDTH-1:0]     stop_time,
    output logic [DT_WIDTH-1:0]       emu_dt,
    output logic                      emu_dt_valid,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic [N_REQ-1:0]          winner,
    output logic [1:0]                state_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [DT_WIDTH-1:0] DtMax = {1'b0, {(DT_WIDTH-1){1'b1}}};

    state_e                state_q, state_d;
    logic [DT_WIDTH-1:0]   dt_q, dt_d;
    logic                  valid_q, valid_d;
    logic [TIME_WIDTH-1:0] time_q, time_d;
    logic [N_REQ-1:0]      win_q, win_d;

    logic [DT_WIDTH-1:0]   req_cur;
    logic [DT_WIDTH-1:0]   best_dt;
    logic [N_REQ-1:0]      best_oh;
    logic                  found;

    logic [TIME_WIDTH:0]   rem;
    logic                  rem_neg;
    logic                  rem_small;
    logic                  clamp;
    logic [DT_WIDTH-1:0]   step_dt;
    logic [N_REQ-1:0]      step_oh;
    logic [TIME_WIDTH-1:0] next_time;
    logic                  hits_stop;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        req_cur = '0;
        best_dt = DtMax;
        best_oh = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_cur = dt_req[i*DT_WIDTH +: DT_WIDTH];
            if (req_en[i] && !req_cur[DT_WIDTH-1] && (!found || req_cur < best_dt)) begin
                best_dt    = req_cur;
                best_oh    = '0;
                best_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // rem is one bit wider so a stop_time lowered below emu_time shows up as negative.
    always_comb begin
        rem       = {1'b0, stop_time} - {1'b0, time_q};
        rem_neg   = rem[TIME_WIDTH];
        rem_small = (rem[TIME_WIDTH:DT_WIDTH-1] == '0);
        clamp     = rem_small && (rem[DT_WIDTH-2:0] < best_dt[DT_WIDTH-2:0]);
        step_dt   = clamp ? {1'b0, rem[DT_WIDTH-2:0]} : best_dt;
        step_oh   = clamp ? '0 : best_oh;
        next_time = time_q + {{(TIME_WIDTH-DT_WIDTH){1'b0}}, step_dt};
        hits_stop = (next_time == stop_time);
    end

    always_comb begin
        state_d = state_q;
        dt_d    = '0;
        valid_d = 1'b0;
        win_d   = '0;
        time_d  = time_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (stop_time == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (rem_neg) begin
                    state_d = StDone;
                end else if (hits_stop || !pause) begin
                    // Reaching stop_time takes priority over a simultaneous pause.
                    dt_d    = step_dt;
                    valid_d = 1'b1;
                    win_d   = step_oh;
                    time_d  = next_time;
                    if (hits_stop) begin
                        state_d = StDone;
                    end
                end else begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (!pause) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= StIdle;
            dt_q    <= '0;
            valid_q <= 1'b0;
            time_q  <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            dt_q    <= dt_d;
            valid_q <= valid_d;
            time_q  <= time_d;
            win_q   <= win_d;
        end
    end

    assign emu_dt       = dt_q;
    assign emu_dt_valid = valid_q;
    assign emu_time     = time_q;
    assign winner       = win_q;
    assign state_o      = state_q;

endmodule

// File: doc/emu_dt_sched.md
Name: emu_dt_sched

Overview:
- Timestep scheduler for the FPGA emulation fabric.
- Collects the per-block timestep requests (dt_req) from N analog models, such as the channel core, and issues the minimum as the global timestep emu_dt.
- Accumulates emulated time and sequences run, pause and stop-at-time.
- Sits beside the emulator clock/reset generator and drives the emu_dt net consumed by every analog core.

Parameters:
- N_REQ, 4, number of timestep requesters.
- DT_WIDTH, 27, width of a signed fixed-point timestep (matches `DT_WIDTH).
- TIME_WIDTH, 48, width of the unsigned emulated-time accumulator.

Ports:
- clk  input  1  emulator clock.
- rstb  input  1  synchronous active-low reset.
- dt_req  input  N_REQ*DT_WIDTH  flattened signed requests; requester i occupies bits [i*DT_WIDTH +: DT_WIDTH].
- req_en  input  N_REQ  per-requester participation enable.
- start  input  1  pulse: leave IDLE and begin advancing time.
- pause  input  1  level: hold time while high.
- stop_time  input  TIME_WIDTH  emulated time at which to halt.
- emu_dt  output  DT_WIDTH  issued timestep, signed, always >= 0.
- emu_dt_valid  output  1  high when emu_dt is being applied this cycle.
- emu_time  output  TIME_WIDTH  accumulated emulated time.
- winner  output  N_REQ  one-hot index of the requester that set emu_dt.
- state_o  output  2  encoded FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.

Behaviour:
- Reset (rstb=0 at a clk edge): state=IDLE, emu_dt=0, emu_dt_valid=0, emu_time=0, winner=0. Reset overrides everything, including a mid-RUN state.
- Request qualification: requester i is eligible when req_en[i]=1 and dt_req_i has its sign bit clear. Negative requests are ignored. A zero request is legal.
- Minimum: smallest eligible request. Ties go to the lowest index. With no eligible requester, the candidate is DT_MAX = {0, all ones} and winner=0.
- Clamp: candidate is limited to rem = stop_time - emu_time when rem < candidate. When the clamp applies, winner=0.
- Latency: one cycle. Requests sampled at edge t produce emu_dt/winner registered at t+1, and emu_time(t+1) = emu_time(t) + emu_dt(t+1). emu_time always equals the sum of all issued timesteps.
- FSM transitions:
  - IDLE: emu_dt_valid=0, emu_dt=0. On start=1 go to RUN, or to DONE if stop_time==0.
  - RUN: emu_dt_valid=1 each cycle and time advances.
    - pause=1 -> PAUSE; that edge issues nothing (emu_dt=0, valid=0).
    - If the issued step makes emu_time==stop_time -> DONE.
    - pause and reaching stop_time in the same cycle: DONE wins.
  - PAUSE: emu_dt=0, valid=0, emu_time held. pause=0 -> RUN; the first step issues at the following edge.
  - DONE: emu_dt=0, valid=0, emu_time held at stop_time. Only reset exits DONE. start is ignored.
- start is ignored outside IDLE.
- stop_time is sampled continuously. If it is lowered below emu_time while in RUN, go to DONE next edge with no step issued; emu_time is not decremented.
- Width rules:
  - rem is computed at TIME_WIDTH+1 bits. rem >= 2^(DT_WIDTH-1) counts as unclamped.
  - emu_time addition zero-extends emu_dt.
  - Overflow cannot occur because the stop clamp applies first.

Test Plan:
- Reset/idle: hold rstb=0 3 cycles, release, no start -> emu_dt=0, valid=0, emu_time=0, state_o=0 for 10 cycles.
- Min select: req={100,40,40,300}, all enabled, start, stop_time=1000 -> emu_dt=40, winner=0010, emu_time 40,80,...; first valid step one cycle after start.
- Eligibility: req={-5,0x7FFFFFF,0,50}, req_en=1011 -> requester 0 ignored (negative), requester 2 disabled, emu_dt=50, winner=1000. With req_en=0000 -> emu_dt=DT_MAX (0x3FFFFFF), winner=0.
- Stop clamp: req all 30, stop_time=100 -> steps 30,30,30,10. emu_time ends at 100, winner=0 on the last step, then DONE, valid=0. A later start pulse has no effect.
- Pause: during RUN at emu_time=60 assert pause 5 cycles -> valid=0, emu_time holds 60. Deassert -> stepping resumes at the following edge. Assert pause on the same cycle the last step hits stop_time -> state_o=3.
- Mid-run reset: rstb=0 for one cycle while in RUN at emu_time=90 -> next cycle emu_time=0, state IDLE, outputs zero.
